// File: rtl/frog_motion_ctrl_if.sv
// Frame-tick, button, respawn and scan inputs plus frog position/pixel outputs
// shared between frog_motion_ctrl (slave) and whatever drives it (master).
interface frog_motion_ctrl_if;
  logic       update;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       respawn;
  logic [9:0] xCount;
  logic [9:0] yCount;
  logic       frog;
  logic [9:0] frog_x;
  logic [9:0] frog_y;
  logic [7:0] hop_count;

  modport master (
    output update, up, down, left, right, respawn, xCount, yCount,
    input  frog, frog_x, frog_y, hop_count
  );

  modport slave (
    input  update, up, down, left, right, respawn, xCount, yCount,
    output frog, frog_x, frog_y, hop_count
  );
endinterface

// File: rtl/frog_motion_ctrl.sv
// Frog movement: per-frame button debounce, one clamped lane hop per press, cooldown, pixel output.
// Optional FROG_AUTOREPEAT_EN: re-hop every REPEAT_FRM frames while a direction stays held.
module frog_motion_ctrl #(
  parameter int unsigned STEP         = 25,
  parameter int unsigned FROG_SIZE    = 20,
  parameter int unsigned START_X      = 310,
  parameter int unsigned START_Y      = 445,
  parameter int unsigned DEBOUNCE_FRM = 2,
  parameter int unsigned COOLDOWN_FRM = 4
`ifdef FROG_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_FRM   = 8
`endif
) (
  input logic               clk,
  input logic               rst,
  frog_motion_ctrl_if.slave bus
);
  localparam int unsigned DBW = $clog2(DEBOUNCE_FRM + 1);
  localparam int unsigned CW  = $clog2(COOLDOWN_FRM + 1);

  localparam logic [DBW-1:0] DB_MAX    = DBW'(DEBOUNCE_FRM);
  localparam logic [DBW-1:0] DB_PRE    = DBW'(DEBOUNCE_FRM - 1);
  localparam logic [CW-1:0]  COOL_LOAD = CW'(COOLDOWN_FRM);

  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] SIZE_W  = 11'(FROG_SIZE);
  localparam logic [10:0] EDGE_LO = 11'd15;
  localparam logic [10:0] LO_LIM  = 11'(15 + STEP);
  localparam logic [10:0] Y_MAX   = 11'(465 - FROG_SIZE);
  localparam logic [10:0] X_MAX   = 11'(630 - FROG_SIZE);
  localparam logic [9:0]  X0      = 10'(START_X);
  localparam logic [9:0]  Y0      = 10'(START_Y);

  typedef enum logic {READY, COOL} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cool_cnt, cool_n;
  logic [3:0][DBW-1:0]  db_cnt;
  logic [3:0]           pressed;
  logic [3:0]           ev;
  logic [3:0]           hop_sel;
  logic                 hop_req;
  logic                 hop_go;
  logic [9:0]           pos_x, pos_y, x_n, y_n;
  logic [10:0]          xw, yw, scan_x, scan_y;
  logic [7:0]           hops;
  logic                 frog_q;

  // Bit order is also hop priority: up, down, left, right.
  assign pressed = {bus.right, bus.left, bus.down, bus.up};
  assign xw      = {1'b0, pos_x};
  assign yw      = {1'b0, pos_y};
  assign scan_x  = {1'b0, bus.xCount};
  assign scan_y  = {1'b0, bus.yCount};

  // A press event is the update on which the counter reaches DB_MAX.
  always_comb begin
    ev = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      ev[i] = pressed[i] && (db_cnt[i] == DB_PRE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.respawn) begin
      db_cnt <= '0;
    end else if (bus.update) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (!pressed[i])                db_cnt[i] <= '0;
        else if (db_cnt[i] != DB_MAX)   db_cnt[i] <= db_cnt[i] + 1'b1;
      end
    end
  end

`ifdef FROG_AUTOREPEAT_EN
  localparam int unsigned         RW       = $clog2(REPEAT_FRM + 1);
  localparam logic [RW-1:0]       REP_LOAD = RW'(REPEAT_FRM);

  logic [RW-1:0] rep_cnt;
  logic [3:0]    stable;

  always_comb begin
    stable = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      stable[i] = pressed[i] && (db_cnt[i] == DB_MAX);
    end
  end

  // rep_cnt parks at 1 while cooldown is still running, so cooldown bounds the spacing.
  assign hop_req = (|ev) || ((rep_cnt == RW'(1)) && (|stable));
  assign hop_sel = (|ev) ? ev : stable;

  always_ff @(posedge clk) begin
    if (rst || bus.respawn) begin
      rep_cnt <= '0;
    end else if (bus.update) begin
      if (hop_go)                  rep_cnt <= REP_LOAD;
      else if (!(|stable))         rep_cnt <= '0;
      else if (rep_cnt > RW'(1))   rep_cnt <= rep_cnt - 1'b1;
    end
  end
`else
  assign hop_req = |ev;
  assign hop_sel = ev;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= READY;
      cool_cnt <= '0;
    end else begin
      state    <= state_n;
      cool_cnt <= cool_n;
    end
  end

  always_comb begin
    state_n = state;
    cool_n  = cool_cnt;
    hop_go  = 1'b0;
    if (bus.respawn) begin
      state_n = READY;
      cool_n  = '0;
    end else if (bus.update) begin
      case (state)
        READY: begin
          if (hop_req) begin
            hop_go  = 1'b1;
            state_n = COOL;
            cool_n  = COOL_LOAD;
          end
        end
        COOL: begin
          if (cool_cnt <= CW'(1)) state_n = READY;
          else                    cool_n  = cool_cnt - 1'b1;
        end
      endcase
    end
  end

  // Compare before stepping so the 10-bit position never wraps at an edge.
  always_comb begin
    x_n = pos_x;
    y_n = pos_y;
    if (hop_sel[0])      y_n = (yw >= LO_LIM)          ? 10'(yw - STEP_W) : 10'(EDGE_LO);
    else if (hop_sel[1]) y_n = (yw + STEP_W <= Y_MAX)  ? 10'(yw + STEP_W) : 10'(Y_MAX);
    else if (hop_sel[2]) x_n = (xw >= LO_LIM)          ? 10'(xw - STEP_W) : 10'(EDGE_LO);
    else if (hop_sel[3]) x_n = (xw + STEP_W <= X_MAX)  ? 10'(xw + STEP_W) : 10'(X_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst || bus.respawn) begin
      pos_x <= X0;
      pos_y <= Y0;
      hops  <= '0;
    end else if (hop_go) begin
      pos_x <= x_n;
      pos_y <= y_n;
      if (hops != '1) hops <= hops + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) frog_q <= 1'b0;
    else     frog_q <= (scan_x >= xw) && (scan_x < xw + SIZE_W) &&
                       (scan_y >= yw) && (scan_y < yw + SIZE_W);
  end

  assign bus.frog      = frog_q;
  assign bus.frog_x    = pos_x;
  assign bus.frog_y    = pos_y;
  assign bus.hop_count = hops;
endmodule
